full_adder_reg: RTL and testbench



---
 rtl/full_adder_pkg.sv | 43 ++++
 rtl/full_adder_cell.sv | 14 +
 rtl/full_adder_reg.sv | 103 ++++++++++
 tb/tb_full_adder_reg.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/full_adder_pkg.sv
// Shared definitions for the registered full adder.
// Holds the width limit, a wide result record and a behavioural add helper
// that mirrors a + b + cin at an arbitrary width (1..FA_MAX_WIDTH).
// Optional feature macro used by the top: FULL_ADDER_OVF_EN.
package full_adder_pkg;

    localparam int unsigned FA_MAX_WIDTH = 64;

    // Result record at the maximum width; callers use the low `width` bits
    // of sum. The top level declares a WIDTH-sized record of the same shape.
    typedef struct packed {
        logic                    carry;
        logic [FA_MAX_WIDTH-1:0] sum;
    } fa_result_t;

    // Behavioural (a + b + cin) at `width` bits: sum is the low `width` bits,
    // carry is bit `width` of the full result. Operand bits above `width`
    // are ignored.
    function automatic fa_result_t fa_add(
        input logic [FA_MAX_WIDTH-1:0] a,
        input logic [FA_MAX_WIDTH-1:0] b,
        input logic                    cin,
        input int unsigned             width
    );
        logic [FA_MAX_WIDTH:0]   full;
        logic [FA_MAX_WIDTH-1:0] mask;
        fa_result_t              res;
        if (width >= FA_MAX_WIDTH) begin
            mask = '1;
        end else begin
            mask = (64'd1 << width) - 64'd1;
        end
        full = {1'b0, a & mask} + {1'b0, b & mask} + {{FA_MAX_WIDTH{1'b0}}, cin};
        res.sum = full[FA_MAX_WIDTH-1:0] & mask;
        if (width >= FA_MAX_WIDTH) begin
            res.carry = full[FA_MAX_WIDTH];
        end else begin
            res.carry = full[width[6:0]];
        end
        return res;
    endfunction

endpackage

// File: rtl/full_adder_cell.sv
// One-bit combinational full adder cell; chained through cout -> cin to
// build a ripple-carry adder of any width.
module full_adder_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic s_o,
    output logic cout_o
);

    assign s_o    = a_i ^ b_i ^ cin_i;
    assign cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);

endmodule

// File: rtl/full_adder_reg.sv
// Registered full adder: a + b + cin through a ripple chain of
// full_adder_cell instances, with sum/carry captured one cycle later.
// Optional signed-overflow output ovf is enabled by FULL_ADDER_OVF_EN.
//
// Handshake: in_valid qualifies a/b/cin for the current cycle only; there is
// no ready. A valid cycle overwrites the result registers and raises
// out_valid for exactly the following cycle; an invalid cycle holds the
// result registers and drops out_valid. Operands are never sampled while
// in_valid is low, so undriven inputs cannot reach the outputs.
module full_adder_reg
    import full_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 1  // legal range 1..FA_MAX_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             carry
`ifdef FULL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    typedef struct packed {
        logic             carry;
        logic [WIDTH-1:0] sum;
    } result_t;

    // Carry chain: c_chain[0] is the carry-in, c_chain[WIDTH] the carry-out.
    logic [WIDTH:0]   c_chain;
    logic [WIDTH-1:0] s_comb;

    result_t res_d, res_q;
    logic    valid_d, valid_q;

    assign c_chain[0] = cin;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_cell
            full_adder_cell u_cell (
                .a_i    (a[gi]),
                .b_i    (b[gi]),
                .cin_i  (c_chain[gi]),
                .s_o    (s_comb[gi]),
                .cout_o (c_chain[gi+1])
            );
        end
    endgenerate

`ifdef FULL_ADDER_OVF_EN
    logic ovf_d, ovf_q;
`endif

    // Next-state: capture the adder result on a valid cycle, otherwise hold.
    always_comb begin
        res_d   = res_q;
        valid_d = in_valid;
`ifdef FULL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        if (in_valid) begin
            res_d.sum   = s_comb;
            res_d.carry = c_chain[WIDTH];
`ifdef FULL_ADDER_OVF_EN
            // Signed overflow: carry into the MSB differs from carry out.
            ovf_d       = c_chain[WIDTH-1] ^ c_chain[WIDTH];
`endif
        end
    end

    // Result and valid registers; reset clears them without waiting for clk,
    // which also discards any operand presented as reset falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q   <= '0;
            valid_q <= 1'b0;
`ifdef FULL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            res_q   <= res_d;
            valid_q <= valid_d;
`ifdef FULL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign sum       = res_q.sum;
    assign carry     = res_q.carry;
    assign out_valid = valid_q;
`ifdef FULL_ADDER_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_full_adder_reg.sv
// Directed bench for full_adder_reg: a WIDTH=1 and a WIDTH=8 instance share
// clock and reset. Inputs change on the falling edge; outputs are checked
// 1 time unit after the rising edge.
module tb_full_adder_reg;
    import full_adder_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic       v1, a1, b1, cin1;
    logic       ov1, s1, c1;
    logic       v8, cin8;
    logic [7:0] a8, b8;
    logic       ov8, c8;
    logic [7:0] s8;
`ifdef FULL_ADDER_OVF_EN
    logic       ovf1, ovf8;
`endif

    full_adder_reg #(.WIDTH(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (v1),
        .a         (a1),
        .b         (b1),
        .cin       (cin1),
        .out_valid (ov1),
        .sum       (s1),
        .carry     (c1)
`ifdef FULL_ADDER_OVF_EN
        ,
        .ovf       (ovf1)
`endif
    );

    full_adder_reg #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (v8),
        .a         (a8),
        .b         (b8),
        .cin       (cin8),
        .out_valid (ov8),
        .sum       (s8),
        .carry     (c8)
`ifdef FULL_ADDER_OVF_EN
        ,
        .ovf       (ovf8)
`endif
    );

    // ---------------- scoreboard ----------------
    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [8:0]  exp_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive1(input logic v, input logic a, input logic b, input logic c);
        v1 = v; a1 = a; b1 = b; cin1 = c;
    endtask

    task automatic drive8(input logic v, input logic [7:0] a, input logic [7:0] b, input logic c);
        v8 = v; a8 = a; b8 = b; cin8 = c;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected tables for WIDTH=1, indexed by {a,b,cin}.
    logic [7:0] exp_s1_tbl = 8'b1001_0110;
    logic [7:0] exp_c1_tbl = 8'b1110_1000;

    initial begin
        logic [2:0]  abc;
        logic [7:0]  ra, rb;
        logic        rc;
        logic [8:0]  e;
        fa_result_t  r;

        // ---------- reset state ----------
        rst_n = 1'b0;
        drive1(1'b0, 1'b0, 1'b0, 1'b0);
        drive8(1'b0, 8'h00, 8'h00, 1'b0);
        tick();
        tick();
        chk("rst_sum1",   {63'b0, s1},  64'd0);
        chk("rst_carry1", {63'b0, c1},  64'd0);
        chk("rst_valid1", {63'b0, ov1}, 64'd0);
        chk("rst_sum8",   {56'b0, s8},  64'd0);
        chk("rst_carry8", {63'b0, c8},  64'd0);
        chk("rst_valid8", {63'b0, ov8}, 64'd0);
`ifdef FULL_ADDER_OVF_EN
        chk("rst_ovf8",   {63'b0, ovf8}, 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_rst_valid1", {63'b0, ov1}, 64'd0);

        // ---------- WIDTH=1 exhaustive, back-to-back ----------
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            abc = i[2:0];
            drive1(1'b1, abc[2], abc[1], abc[0]);
            tick();
            chk($sformatf("w1_sum_%0d", i),   {63'b0, s1},  {63'b0, exp_s1_tbl[i]});
            chk($sformatf("w1_carry_%0d", i), {63'b0, c1},  {63'b0, exp_c1_tbl[i]});
            chk($sformatf("w1_valid_%0d", i), {63'b0, ov1}, 64'd1);
`ifdef FULL_ADDER_OVF_EN
            chk($sformatf("w1_ovf_%0d", i), {63'b0, ovf1},
                {63'b0, (abc[2] == abc[1]) && (exp_s1_tbl[i] != abc[2])});
`endif
        end

        // ---------- hold: capture 1+1+0, then 3 idle cycles with toggling operands ----------
        @(negedge clk);
        drive1(1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        chk("hold_cap_sum",   {63'b0, s1},  64'd0);
        chk("hold_cap_carry", {63'b0, c1},  64'd1);
        chk("hold_cap_valid", {63'b0, ov1}, 64'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive1(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            tick();
            chk($sformatf("hold_sum_%0d", i),   {63'b0, s1},  64'd0);
            chk($sformatf("hold_carry_%0d", i), {63'b0, c1},  64'd1);
            chk($sformatf("hold_valid_%0d", i), {63'b0, ov1}, 64'd0);
        end

        // ---------- reset mid-operation ----------
        @(negedge clk);
        drive1(1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        chk("mr_cap_sum",   {63'b0, s1}, 64'd1);
        chk("mr_cap_carry", {63'b0, c1}, 64'd0);
        drive1(1'b1, 1'b1, 1'b1, 1'b1);   // pending operand, must be discarded
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_async_sum",   {63'b0, s1},  64'd0);
        chk("mr_async_carry", {63'b0, c1},  64'd0);
        chk("mr_async_valid", {63'b0, ov1}, 64'd0);
        tick();
        chk("mr_held_sum",   {63'b0, s1},  64'd0);
        chk("mr_held_valid", {63'b0, ov1}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive1(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("mr_rel_valid", {63'b0, ov1}, 64'd0);
        chk("mr_rel_sum",   {63'b0, s1},  64'd0);
        tick();
        chk("mr_rel_valid2", {63'b0, ov1}, 64'd0);
        @(negedge clk);
        drive1(1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        chk("mr_new_sum",   {63'b0, s1},  64'd0);
        chk("mr_new_carry", {63'b0, c1},  64'd1);
        chk("mr_new_valid", {63'b0, ov1}, 64'd1);
        @(negedge clk);
        drive1(1'b0, 1'b0, 1'b0, 1'b0);

        // ---------- WIDTH=8 wrap / overflow corners ----------
        @(negedge clk);
        drive8(1'b1, 8'hFF, 8'h01, 1'b0);
        tick();
        chk("w8_ff01_sum",   {56'b0, s8}, 64'h00);
        chk("w8_ff01_carry", {63'b0, c8}, 64'd1);
        @(negedge clk);
        drive8(1'b1, 8'hFF, 8'hFF, 1'b1);
        tick();
        chk("w8_ffff1_sum",   {56'b0, s8}, 64'hFF);
        chk("w8_ffff1_carry", {63'b0, c8}, 64'd1);
        @(negedge clk);
        drive8(1'b1, 8'h7F, 8'h01, 1'b0);
        tick();
        chk("w8_7f01_sum",   {56'b0, s8}, 64'h80);
        chk("w8_7f01_carry", {63'b0, c8}, 64'd0);
`ifdef FULL_ADDER_OVF_EN
        chk("w8_7f01_ovf",   {63'b0, ovf8}, 64'd1);
`endif
        @(negedge clk);
        drive8(1'b1, 8'h80, 8'h80, 1'b0);
        tick();
        chk("w8_8080_sum",   {56'b0, s8}, 64'h00);
        chk("w8_8080_carry", {63'b0, c8}, 64'd1);
`ifdef FULL_ADDER_OVF_EN
        chk("w8_8080_ovf",   {63'b0, ovf8}, 64'd1);
`endif

        // ---------- WIDTH=8 back-to-back random ----------
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
            r  = fa_add({56'b0, ra}, {56'b0, rb}, rc, 8);
            exp_q.push_back({r.carry, r.sum[7:0]});
            drive8(1'b1, ra, rb, rc);
            tick();
            e = exp_q.pop_front();
            chk($sformatf("rnd_sum_%0d", i),   {56'b0, s8},  {56'b0, e[7:0]});
            chk($sformatf("rnd_carry_%0d", i), {63'b0, c8},  {63'b0, e[8]});
            chk($sformatf("rnd_valid_%0d", i), {63'b0, ov8}, 64'd1);
`ifdef FULL_ADDER_OVF_EN
            chk($sformatf("rnd_ovf_%0d", i), {63'b0, ovf8},
                {63'b0, (ra[7] == rb[7]) && (e[7] != ra[7])});
`endif
        end

        // ---------- WIDTH=8 idle after stream: valid drops, result holds ----------
        @(negedge clk);
        drive8(1'b0, 8'h5A, 8'hA5, 1'b1);
        tick();
        chk("w8_idle_valid", {63'b0, ov8}, 64'd0);
        chk("w8_idle_sum",   {56'b0, s8},  {56'b0, e[7:0]});
        chk("w8_idle_carry", {63'b0, c8},  {63'b0, e[8]});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
